// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the UART-driven 7-segment display.
// Contents: hex font ({g..a}, active-high), ASCII control codes, the digit buffer entry type,
// and byte classification used when SEG7_ASCII_EN is defined.
package seg7_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       blank;
        logic [3:0] nibble;
    } digit_t;

    localparam digit_t BLANK_DIGIT = '{blank: 1'b1, nibble: 4'h0};

    typedef enum logic [2:0] {
        ClsHex,
        ClsBs,
        ClsEsc,
        ClsIgnore,
        ClsBad
    } byte_cls_e;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic byte_cls_e classify_byte(input logic [7:0] c);
        byte_cls_e cls;
        if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
            (c >= 8'h61 && c <= 8'h66)) begin
            cls = ClsHex;
        end else if (c == ASCII_BS) begin
            cls = ClsBs;
        end else if (c == ASCII_ESC) begin
            cls = ClsEsc;
        end else if (c == ASCII_CR || c == ASCII_LF) begin
            cls = ClsIgnore;
        end else begin
            cls = ClsBad;
        end
        return cls;
    endfunction

    // Only meaningful for bytes classified as ClsHex; 'A' and 'a' share the low nibble 1.
    function automatic logic [3:0] ascii_nibble(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational {blank, nibble} to active-high segments {g..a}.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic       blank,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Blank digits override the font
    always_comb begin
        seg = blank ? SEG_BLANK : hex_font(nibble);
    end

endmodule

// File: rtl/uart_seg7_display.sv
// uart_seg7_display: shows bytes received from UART RX as hex digits on a multiplexed
// 7-segment display. Optional macro SEG7_ASCII_EN: ASCII terminal decoding (hex chars, BS, ESC,
// CR/LF ignored, bad_char pulse with dp indication). Without it each byte is shown as two raw
// hex digits, bad_char is 0 and dp stays off.
module uart_seg7_display
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 27000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              bad_char
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam logic [6:0]        SEG_INV   = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_INV    = {DIGITS{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_DIGIT0 = {{(DIGITS-1){1'b0}}, 1'b1};

    digit_t [DIGITS-1:0] disp_q, disp_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                scan_tick;
    digit_t              cur_digit;
    logic [6:0]          font_seg;
    logic [DIGITS-1:0]   an_onehot;
    logic                dp_lit;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic                dp_q;

    // Prescaler and scan index advance
    always_comb begin
        scan_tick = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d     = scan_tick ? '0 : pre_q + PRE_W'(1);
        idx_d     = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef SEG7_ASCII_EN
    localparam int unsigned DP_CYCLES = 2 * DIGITS * REFRESH_DIV;
    localparam int unsigned DP_W      = $clog2(DP_CYCLES + 1);

    logic [DP_W-1:0] dp_cnt_q, dp_cnt_d;
    logic            bad_q, bad_d;
    digit_t          new_digit;

    // Decode one received character into buffer edits, bad-char pulse and dp timer
    always_comb begin
        disp_d    = disp_q;
        bad_d     = 1'b0;
        dp_cnt_d  = (dp_cnt_q != '0) ? dp_cnt_q - DP_W'(1) : '0;
        new_digit = '{blank: 1'b0, nibble: ascii_nibble(rx_data)};
        if (rx_valid) begin
            case (classify_byte(rx_data))
                ClsHex: begin
                    for (int i = int'(DIGITS) - 1; i > 0; i--) disp_d[i] = disp_q[i-1];
                    disp_d[0] = new_digit;
                    dp_cnt_d  = '0;
                end
                ClsBs: begin
                    for (int i = 0; i < int'(DIGITS) - 1; i++) disp_d[i] = disp_q[i+1];
                    disp_d[DIGITS-1] = BLANK_DIGIT;
                end
                ClsEsc: begin
                    disp_d = {DIGITS{BLANK_DIGIT}};
                end
                ClsBad: begin
                    bad_d    = 1'b1;
                    dp_cnt_d = DP_W'(DP_CYCLES);
                end
                default: ;
            endcase
        end
    end

    // Bad-char pulse and dp hold timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_q    <= 1'b0;
            dp_cnt_q <= '0;
        end else begin
            bad_q    <= bad_d;
            dp_cnt_q <= dp_cnt_d;
        end
    end

    assign dp_lit   = (dp_cnt_q != '0) && (idx_q == '0);
    assign bad_char = bad_q;
`else
    // Raw mode: each byte pushes two nibbles in, high nibble on digit 1
    always_comb begin
        disp_d = disp_q;
        if (rx_valid) begin
            for (int i = int'(DIGITS) - 1; i > 1; i--) disp_d[i] = disp_q[i-2];
            disp_d[1] = '{blank: 1'b0, nibble: rx_data[7:4]};
            disp_d[0] = '{blank: 1'b0, nibble: rx_data[3:0]};
        end
    end

    assign dp_lit   = 1'b0;
    assign bad_char = 1'b0;
`endif

    // Digit buffer, prescaler and scan index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= {DIGITS{BLANK_DIGIT}};
            pre_q  <= '0;
            idx_q  <= '0;
        end else begin
            disp_q <= disp_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
        end
    end

    assign cur_digit = disp_q[idx_q];
    assign an_onehot = AN_DIGIT0 << idx_q;

    seg7_hex_decoder u_hex_decoder (
        .blank  (cur_digit.blank),
        .nibble (cur_digit.nibble),
        .seg    (font_seg)
    );

    // Output registers sample the pre-edge scan index and buffer; polarity applied here only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_INV;
            an_q  <= AN_DIGIT0 ^ AN_INV;
            dp_q  <= SEG_ACTIVE_LOW;
        end else begin
            seg_q <= font_seg ^ SEG_INV;
            an_q  <= an_onehot ^ AN_INV;
            dp_q  <= dp_lit ^ SEG_ACTIVE_LOW;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_uart_seg7_display.sv
// tb_uart_seg7_display: directed bench with a digit-list display model and per-cycle compare.
// Build with SEG7_ASCII_EN to exercise ASCII terminal mode; raw mode otherwise.
module tb_uart_seg7_display;

    localparam int D   = 4;
    localparam int RD  = 4;
    localparam int DPW = 2 * D * RD;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       bad_char;

    int total = 0;
    int bad   = 0;

    uart_seg7_display #(
        .DIGITS         (D),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .bad_char (bad_char)
    );

    always #5 clk = ~clk;

    // Active-high {g..a} patterns of hex digits
    function automatic logic [6:0] font_of(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Digit lit during the cycle that ends with edge number k+1 (k edges since reset)
    function automatic int scan_of(input int k);
        return (k / RD) % D;
    endfunction

    // Model: digit list (-1 = blank), edge counter, dp window in edge numbers
    int         dig [4] = '{-1, -1, -1, -1};
    int         n_edge   = 0;
    int         dp_from  = 0;
    int         dp_until = 0;
    logic [6:0] exp_seg  = 7'h7F;
    logic [3:0] exp_an   = 4'b1110;
    logic       exp_dp   = 1'b1;
    logic       exp_bad  = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_edge   <= 0;
            dp_from  <= 0;
            dp_until <= 0;
            for (int i = 0; i < 4; i++) dig[i] <= -1;
            exp_seg  <= 7'h7F;
            exp_an   <= 4'b1110;
            exp_dp   <= 1'b1;
            exp_bad  <= 1'b0;
        end else begin
            n_edge  <= n_edge + 1;
            exp_seg <= (dig[scan_of(n_edge)] < 0) ? 7'h7F : ~font_of(dig[scan_of(n_edge)]);
            exp_an  <= ~(4'b0001 << scan_of(n_edge));
            exp_bad <= 1'b0;
`ifdef SEG7_ASCII_EN
            exp_dp  <= !(scan_of(n_edge) == 0 && n_edge + 1 > dp_from && n_edge + 1 <= dp_until);
`else
            exp_dp  <= 1'b1;
`endif
            if (rx_valid) begin
`ifdef SEG7_ASCII_EN
                if (hexval(rx_data) >= 0) begin
                    dig[3] <= dig[2];
                    dig[2] <= dig[1];
                    dig[1] <= dig[0];
                    dig[0] <= hexval(rx_data);
                    if (dp_until > n_edge + 1) dp_until <= n_edge + 1;
                end else if (rx_data == 8'h08) begin
                    dig[0] <= dig[1];
                    dig[1] <= dig[2];
                    dig[2] <= dig[3];
                    dig[3] <= -1;
                end else if (rx_data == 8'h1B) begin
                    for (int i = 0; i < 4; i++) dig[i] <= -1;
                end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                    dig[0] <= dig[0];
                end else begin
                    exp_bad  <= 1'b1;
                    dp_from  <= n_edge + 1;
                    dp_until <= n_edge + 1 + DPW;
                end
`else
                dig[3] <= dig[1];
                dig[2] <= dig[0];
                dig[1] <= int'(rx_data[7:4]);
                dig[0] <= int'(rx_data[3:0]);
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        check("cmp_seg", 32'(seg), 32'(exp_seg));
        check("cmp_an", 32'(an), 32'(exp_an));
        check("cmp_dp", 32'(dp), 32'(exp_dp));
        check("cmp_bad", 32'(bad_char), 32'(exp_bad));
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Wait (bounded) until digit d is scanned and return its segments
    task automatic get_digit(input int d, output logic [6:0] s);
        logic [3:0] want;
        bit         found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        s     = 7'h00;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (an == want) begin
                found = 1'b1;
                s     = seg;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL scan_timeout: digit %0d never scanned, an=%b", d, an);
        end
    endtask

    initial begin
        logic [6:0] s;
        logic       saw;

        #1 reset_n = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'b1110);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_bad", 32'(bad_char), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("an_rotate", 32'(an), 32'b1101);

`ifdef SEG7_ASCII_EN
        send(8'h31);
        send(8'h41);
        get_digit(1, s); check("a_d1", 32'(s), 32'b1111001);
        get_digit(0, s); check("a_d0", 32'(s), 32'b0001000);
        get_digit(3, s); check("a_d3", 32'(s), 32'h7F);
        get_digit(2, s); check("a_d2", 32'(s), 32'h7F);

        for (int c = 8'h31; c <= 8'h35; c++) send(8'(c));
        get_digit(3, s); check("s_d3", 32'(s), 32'b0100100);
        get_digit(2, s); check("s_d2", 32'(s), 32'b0110000);
        get_digit(1, s); check("s_d1", 32'(s), 32'b0011001);
        get_digit(0, s); check("s_d0", 32'(s), 32'b0010010);

        send(8'h08);
        get_digit(3, s); check("bs_d3", 32'(s), 32'h7F);
        get_digit(0, s); check("bs_d0", 32'(s), 32'b0011001);

        send(8'h1B);
        repeat (16) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            get_digit(d, s);
            check("esc_blank", 32'(s), 32'h7F);
        end

        send(8'h0D);
        send(8'h0A);
        send(8'h43);

        @(negedge clk);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("z_pulse", 32'(bad_char), 32'd1);
        @(negedge clk);
        check("z_pulse_end", 32'(bad_char), 32'd0);
        saw = 1'b0;
        repeat (32) begin
            @(negedge clk);
            if (an == 4'b1110 && dp == 1'b0) saw = 1'b1;
        end
        check("z_dp_lit", 32'(saw), 32'd1);
        saw = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (dp == 1'b0) saw = 1'b1;
        end
        check("z_dp_off", 32'(saw), 32'd0);
        get_digit(0, s); check("z_buf_kept", 32'(s), 32'b1000110);
`else
        send(8'hA5);
        get_digit(1, s); check("r_d1", 32'(s), 32'b0001000);
        get_digit(0, s); check("r_d0", 32'(s), 32'b0010010);
        get_digit(3, s); check("r_d3", 32'(s), 32'h7F);
        get_digit(2, s); check("r_d2", 32'(s), 32'h7F);

        send(8'h3C);
        get_digit(3, s); check("r2_d3", 32'(s), 32'b0001000);
        get_digit(2, s); check("r2_d2", 32'(s), 32'b0010010);
        get_digit(1, s); check("r2_d1", 32'(s), 32'b0110000);
        get_digit(0, s); check("r2_d0", 32'(s), 32'b1000110);
`endif

        // Asynchronous reset between clock edges, mid-scan
        get_digit(1, s);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an", 32'(an), 32'b1110);
        check("arst_dp", 32'(dp), 32'd1);
        check("arst_bad", 32'(bad_char), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        get_digit(1, s); check("arst_cleared", 32'(s), 32'h7F);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
